// File: rtl/udp_pkt_pkg.sv
// ============================================================================
// Module      : udp_pkt_pkg
// Description : Shared constants, state encoding and ones-complement helper
//               for the UDP frame transmitter/receiver pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_pkt_pkg;

  localparam logic [15:0] C_ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  C_VER_IHL        = 8'h45;
  localparam logic [7:0]  C_PROTO_UDP      = 8'h11;
  localparam int          C_HDR_WORDS      = 11;

  localparam int C_FLAG_SOF    = 0;
  localparam int C_FLAG_EOF    = 1;
  localparam int C_FLAG_OCC_LO = 2;
  localparam int C_FLAG_OCC_HI = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } pkt_state_t;

  // End-around-carry add; a single fold suffices since the carry cannot ripple twice.
  function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_packet_receiver_ip_checksum_verify.sv
// ============================================================================
// Module      : ip_checksum_verify
// Description : Running ones-complement sum of IPv4 header halfwords; ok is
//               high when the folded sum equals 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_checksum_verify
  import udp_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enab,
  input  logic [15:0] halfword,
  output logic        ok
);

  logic [15:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sum <= 16'd0;
    end else if (enab) begin
      r_sum <= oc_add16(r_sum, halfword);
    end
  end

  assign ok = (r_sum == 16'hFFFF);

endmodule

`default_nettype wire

// File: rtl/udp_packet_receiver.sv
// ============================================================================
// Module      : udp_packet_receiver
// Description : Parses Ethernet/IPv4/UDP headers from the MAC RX FIFO, filters
//               on MAC/IP/port and streams payload words to a payload FIFO.
//               Define RX_IP_CHECKSUM_EN to also verify the IPv4 header checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_packet_receiver
  import udp_pkt_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h0037_ffff_3737,
  parameter logic [31:0] MY_IP     = 32'ha9fe_4d01,
  parameter logic [15:0] MY_PORT   = 16'h1234,
  parameter int          MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rd_flags_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_src_rdy_i,
  output logic        rd_dst_rdy_o,
  output logic [31:0] pkt_d_o,
  output logic        pkt_wr_o,
  input  logic        pkt_full_i,
  output logic        pkt_done_o,
  output logic        pkt_err_o,
  output logic [8:0]  pkt_size_o,
  output logic [15:0] drop_count_o
);

  pkt_state_t  r_state, w_state_nxt;
  logic [3:0]  r_index, w_index_nxt;
  logic        r_bad, w_bad_nxt;
  logic        r_mac_my, w_mac_my_nxt;
  logic        r_mac_bc, w_mac_bc_nxt;
  logic [15:0] r_udp_len, w_udp_len_nxt;
  logic [8:0]  r_count, w_count_nxt;
  logic [31:0] r_pkt_d, w_pkt_d_nxt;
  logic        r_pkt_wr, w_pkt_wr_nxt;
  logic        r_pkt_done, w_pkt_done_nxt;
  logic        r_pkt_err, w_pkt_err_nxt;
  logic [8:0]  r_pkt_size, w_pkt_size_nxt;
  logic [15:0] r_drop_count;
  logic        w_drop_inc, w_start, w_csum_ok;

  wire w_xfer = rd_src_rdy_i && rd_dst_rdy_o;
  wire w_sof  = rd_flags_i[C_FLAG_SOF];
  wire w_eof  = rd_flags_i[C_FLAG_EOF];
  wire [1:0] w_occ = rd_flags_i[C_FLAG_OCC_HI:C_FLAG_OCC_LO];

  assign rd_dst_rdy_o = !reset && ((r_state != ST_PAYLOAD) || !pkt_full_i);

`ifdef RX_IP_CHECKSUM_EN
  logic        w_csum_enab;
  logic [15:0] w_csum_half;

  // w3 and w8 contribute one halfword each, w4..w7 contribute both halves.
  always_comb begin
    w_csum_half = oc_add16(rd_data_i[31:16], rd_data_i[15:0]);
    if (r_index == 4'd3)      w_csum_half = rd_data_i[15:0];
    else if (r_index == 4'd8) w_csum_half = rd_data_i[31:16];
  end

  assign w_csum_enab = w_xfer && !w_sof && !w_eof && (r_state == ST_HDR) &&
                       (r_index >= 4'd3) && (r_index <= 4'd8);

  ip_checksum_verify u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_xfer && w_sof),
    .enab     (w_csum_enab),
    .halfword (w_csum_half),
    .ok       (w_csum_ok)
  );
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_bad_nxt      = r_bad;
    w_mac_my_nxt   = r_mac_my;
    w_mac_bc_nxt   = r_mac_bc;
    w_udp_len_nxt  = r_udp_len;
    w_count_nxt    = r_count;
    w_pkt_d_nxt    = r_pkt_d;
    w_pkt_wr_nxt   = 1'b0;
    w_pkt_done_nxt = 1'b0;
    w_pkt_err_nxt  = 1'b0;
    w_pkt_size_nxt = r_pkt_size;
    w_drop_inc     = 1'b0;
    w_start        = 1'b0;

    if (w_xfer) begin
      case (r_state)
        ST_IDLE: w_start = w_sof;

        ST_HDR: begin
          if (w_sof) begin
            w_drop_inc = 1'b1;
            w_start    = 1'b1;
          end else if (w_eof) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_index_nxt = r_index + 4'd1;
            if (r_index == 4'd1 &&
                !((r_mac_my && rd_data_i[31:16] == MY_MAC[15:0]) ||
                  (r_mac_bc && rd_data_i[31:16] == 16'hFFFF)))
              w_bad_nxt = 1'b1;
            if (r_index == 4'd3 &&
                (rd_data_i[31:16] != C_ETHERTYPE_IPV4 || rd_data_i[15:8] != C_VER_IHL))
              w_bad_nxt = 1'b1;
            if (r_index == 4'd5 && rd_data_i[7:0] != C_PROTO_UDP)
              w_bad_nxt = 1'b1;
            if (r_index == 4'd7 && rd_data_i[15:0] != MY_IP[31:16])
              w_bad_nxt = 1'b1;
            if (r_index == 4'd8 && rd_data_i[31:16] != MY_IP[15:0])
              w_bad_nxt = 1'b1;
            if (r_index == 4'd9) begin
              w_udp_len_nxt = rd_data_i[15:0];
              if (rd_data_i[31:16] != MY_PORT) w_bad_nxt = 1'b1;
            end
            if (r_index == 4'(C_HDR_WORDS - 1)) begin
              w_count_nxt = 9'd0;
              if (r_bad || !w_csum_ok) begin
                w_state_nxt = ST_DISCARD;
                w_drop_inc  = 1'b1;
              end else begin
                w_state_nxt = ST_PAYLOAD;
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (w_sof) begin
            // Aborted packet: report only the words already written.
            w_pkt_done_nxt = 1'b1;
            w_pkt_err_nxt  = 1'b1;
            w_pkt_size_nxt = r_count - 9'd1;
            w_drop_inc     = 1'b1;
            w_start        = 1'b1;
          end else begin
            w_pkt_wr_nxt = 1'b1;
            w_pkt_d_nxt  = rd_data_i;
            if (w_eof) begin
              w_pkt_done_nxt = 1'b1;
              w_pkt_size_nxt = r_count;
              w_pkt_err_nxt  = (w_occ != 2'b00) ||
                               (r_udp_len != ({5'd0, r_count, 2'b00} + 16'd10));
              w_drop_inc     = w_pkt_err_nxt;
              w_state_nxt    = ST_IDLE;
            end else if (r_count == 9'(MAX_WORDS - 1)) begin
              w_pkt_done_nxt = 1'b1;
              w_pkt_err_nxt  = 1'b1;
              w_pkt_size_nxt = r_count;
              w_drop_inc     = 1'b1;
              w_state_nxt    = ST_DISCARD;
            end else begin
              w_count_nxt = r_count + 9'd1;
            end
          end
        end

        ST_DISCARD: begin
          if (w_sof)      w_start     = 1'b1;
          else if (w_eof) w_state_nxt = ST_IDLE;
        end

        default: w_state_nxt = ST_IDLE;
      endcase

      if (w_start) begin
        if (w_eof) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt  = ST_HDR;
          w_index_nxt  = 4'd1;
          w_bad_nxt    = 1'b0;
          w_mac_my_nxt = (rd_data_i == MY_MAC[47:16]);
          w_mac_bc_nxt = (rd_data_i == 32'hFFFF_FFFF);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_index      <= 4'd0;
      r_bad        <= 1'b0;
      r_mac_my     <= 1'b0;
      r_mac_bc     <= 1'b0;
      r_udp_len    <= 16'd0;
      r_count      <= 9'd0;
      r_pkt_d      <= 32'd0;
      r_pkt_wr     <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_err    <= 1'b0;
      r_pkt_size   <= 9'd0;
      r_drop_count <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_bad      <= w_bad_nxt;
      r_mac_my   <= w_mac_my_nxt;
      r_mac_bc   <= w_mac_bc_nxt;
      r_udp_len  <= w_udp_len_nxt;
      r_count    <= w_count_nxt;
      r_pkt_d    <= w_pkt_d_nxt;
      r_pkt_wr   <= w_pkt_wr_nxt;
      r_pkt_done <= w_pkt_done_nxt;
      r_pkt_err  <= w_pkt_err_nxt;
      r_pkt_size <= w_pkt_size_nxt;
      if (w_drop_inc && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign pkt_d_o      = r_pkt_d;
  assign pkt_wr_o     = r_pkt_wr;
  assign pkt_done_o   = r_pkt_done;
  assign pkt_err_o    = r_pkt_err;
  assign pkt_size_o   = r_pkt_size;
  assign drop_count_o = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_udp_packet_receiver.sv
// ============================================================================
// Module      : tb_udp_packet_receiver
// Description : Directed, table-driven bench for udp_packet_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_packet_receiver;

  localparam logic [47:0] C_MAC  = 48'h0037_ffff_3737;
  localparam logic [31:0] C_IP   = 32'ha9fe_4d01;
  localparam logic [15:0] C_PORT = 16'h1234;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_flags_i;
  logic [31:0] rd_data_i;
  logic        rd_src_rdy_i;
  logic        rd_dst_rdy_o;
  logic [31:0] pkt_d_o;
  logic        pkt_wr_o;
  logic        pkt_full_i;
  logic        pkt_done_o;
  logic        pkt_err_o;
  logic [8:0]  pkt_size_o;
  logic [15:0] drop_count_o;

  always #5 clk = ~clk;

  udp_packet_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .rd_flags_i   (rd_flags_i),
    .rd_data_i    (rd_data_i),
    .rd_src_rdy_i (rd_src_rdy_i),
    .rd_dst_rdy_o (rd_dst_rdy_o),
    .pkt_d_o      (pkt_d_o),
    .pkt_wr_o     (pkt_wr_o),
    .pkt_full_i   (pkt_full_i),
    .pkt_done_o   (pkt_done_o),
    .pkt_err_o    (pkt_err_o),
    .pkt_size_o   (pkt_size_o),
    .drop_count_o (drop_count_o)
  );

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int low_cnt = 0;

  logic [31:0] got_q[$];
  logic [9:0]  done_q[$];
  logic [35:0] tx_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (pkt_wr_o)   got_q.push_back(pkt_d_o);
    if (pkt_done_o) done_q.push_back({pkt_err_o, pkt_size_o});
    if (!reset && !rd_dst_rdy_o) low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_q.delete();
    exp_q.delete();
    low_cnt = 0;
  endtask

  task automatic build_frame(input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [15:0] dport, input logic [15:0] ulen,
                             input int npay, input logic [1:0] occ, input bit with_eof,
                             input logic [15:0] csum_adj, input logic [7:0] seed);
    logic [31:0] h[11];
    logic [31:0] sum;
    logic [15:0] csum;
    logic [47:0] smac;
    logic [31:0] sip;
    smac  = 48'h0011_2233_4455;
    sip   = 32'hc0a8_0001;
    h[0]  = dmac[47:16];
    h[1]  = {dmac[15:0], smac[47:32]};
    h[2]  = smac[31:0];
    h[3]  = {16'h0800, 8'h45, 8'h00};
    h[4]  = {ulen + 16'd20, 16'h1c46};
    h[5]  = {16'h4000, 8'h40, 8'h11};
    h[7]  = {sip[15:0], dip[31:16]};
    h[8]  = {dip[15:0], 16'h5000};
    h[9]  = {dport, ulen};
    h[10] = 32'h0000_0000;
    sum = {16'd0, h[3][15:0]} + h[4][31:16] + h[4][15:0] + h[5][31:16] + h[5][15:0] +
          sip[31:16] + h[7][31:16] + h[7][15:0] + h[8][31:16];
    sum  = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    sum  = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    csum = ~sum[15:0] + csum_adj;
    h[6] = {csum, sip[31:16]};
    for (int i = 0; i < 11; i++) tx_q.push_back({(i == 0) ? 4'b0001 : 4'b0000, h[i]});
    for (int i = 0; i < npay; i++) begin
      logic [31:0] w;
      w = {seed, 8'hA5, 16'(i)};
      exp_q.push_back(w);
      if (i == npay - 1) tx_q.push_back({occ, with_eof, 1'b0, w});
      else               tx_q.push_back({4'b0000, w});
    end
  endtask

  task automatic put(input logic [35:0] e);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    rd_flags_i   = e[35:32];
    rd_data_i    = e[31:0];
    rd_src_rdy_i = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = rd_dst_rdy_o;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 200) begin
        checks++;
        errors++;
        $display("FAIL put_timeout: got rd_dst_rdy_o=0 for %0d cycles, expected 1", n);
        ok = 1'b1;
      end
    end
  endtask

  task automatic send_q();
    foreach (tx_q[i]) put(tx_q[i]);
    rd_src_rdy_i = 1'b0;
    rd_flags_i   = 4'b0000;
    tx_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_payload(input string name, input int n);
    int bad;
    bad = 0;
    check({name, "_nwords"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    check({name, "_data_mismatches"}, bad, 0);
  endtask

  typedef struct {
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [15:0] ulen;
    int          npay;
    logic [1:0]  occ;
    int          exp_words;
    int          exp_done;
    logic        exp_err;
    logic [8:0]  exp_size;
    int          exp_drop_inc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{C_MAC, C_IP, C_PORT, 16'd22, 4, 2'b00, 4, 1, 1'b0, 9'd3, 0};
    vecs[1] = '{C_MAC, C_IP, 16'h4321, 16'd22, 4, 2'b00, 0, 0, 1'b0, 9'd0, 1};
    vecs[2] = '{48'hFFFF_FFFF_FFFF, C_IP, C_PORT, 16'd14, 2, 2'b00, 2, 1, 1'b0, 9'd1, 0};
    vecs[3] = '{48'h0037_ffff_3738, C_IP, C_PORT, 16'd22, 4, 2'b00, 0, 0, 1'b0, 9'd0, 1};
    vecs[4] = '{C_MAC, 32'ha9fe_4d02, C_PORT, 16'd22, 4, 2'b00, 0, 0, 1'b0, 9'd0, 1};
    vecs[5] = '{C_MAC, C_IP, C_PORT, 16'd18, 3, 2'b01, 3, 1, 1'b1, 9'd2, 1};
    vecs[6] = '{C_MAC, C_IP, C_PORT, 16'd20, 4, 2'b00, 4, 1, 1'b1, 9'd3, 1};
    vecs[7] = '{C_MAC, C_IP, C_PORT, 16'd10, 1, 2'b00, 1, 1, 1'b0, 9'd0, 0};

    reset        = 1'b1;
    rd_flags_i   = 4'b0001;
    rd_data_i    = 32'h0037_ffff;
    rd_src_rdy_i = 1'b1;
    pkt_full_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dst_rdy", rd_dst_rdy_o, 0);
    check("reset_wr", pkt_wr_o, 0);
    check("reset_done", pkt_done_o, 0);
    check("reset_drop", drop_count_o, 0);
    @(posedge clk);
    #1;
    rd_src_rdy_i = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    check("idle_dst_rdy", rd_dst_rdy_o, 1);
    clear_obs();

    // Junk before any SOF is ignored.
    tx_q.push_back({4'b0000, 32'h0037_ffff});
    tx_q.push_back({4'b0010, 32'hdead_beef});
    send_q();
    check("junk_nwords", got_q.size(), 0);
    check("junk_ndone", done_q.size(), 0);

    for (int v = 0; v < 8; v++) begin
      clear_obs();
      build_frame(vecs[v].dmac, vecs[v].dip, vecs[v].dport, vecs[v].ulen, vecs[v].npay,
                  vecs[v].occ, 1'b1, 16'h0000, 8'(v));
      send_q();
      exp_drop += vecs[v].exp_drop_inc;
      check_payload($sformatf("vec%0d", v), vecs[v].exp_words);
      check($sformatf("vec%0d_ndone", v), done_q.size(), vecs[v].exp_done);
      if (vecs[v].exp_done == 1 && done_q.size() == 1)
        check($sformatf("vec%0d_err_size", v), done_q[0], {vecs[v].exp_err, vecs[v].exp_size});
      check($sformatf("vec%0d_drop", v), drop_count_o, exp_drop);
      check($sformatf("vec%0d_dst_rdy_low", v), low_cnt, 0);
    end

    // Backpressure: full held 5 cycles mid-payload.
    clear_obs();
    build_frame(C_MAC, C_IP, C_PORT, 16'd38, 8, 2'b00, 1'b1, 16'h0000, 8'h40);
    fork
      send_q();
      begin
        for (int i = 0; i < 300 && got_q.size() < 2; i++) @(negedge clk);
        @(posedge clk);
        #1;
        pkt_full_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pkt_full_i = 1'b0;
      end
    join
    check("bp_dst_rdy_low", low_cnt, 5);
    check_payload("bp", 8);
    check("bp_ndone", done_q.size(), 1);
    if (done_q.size() == 1) check("bp_err_size", done_q[0], {1'b0, 9'd7});

    // SOF at payload word 2 of packet A, then clean packet B.
    clear_obs();
    build_frame(C_MAC, C_IP, C_PORT, 16'd22, 2, 2'b00, 1'b0, 16'h0000, 8'h50);
    build_frame(C_MAC, C_IP, C_PORT, 16'd22, 4, 2'b00, 1'b1, 16'h0000, 8'h51);
    send_q();
    exp_drop++;
    check_payload("abort", 6);
    check("abort_ndone", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("abort_a", done_q[0], {1'b1, 9'd1});
      check("abort_b", done_q[1], {1'b0, 9'd3});
    end
    check("abort_drop", drop_count_o, exp_drop);

    // EOF during header.
    clear_obs();
    build_frame(C_MAC, C_IP, C_PORT, 16'd22, 4, 2'b00, 1'b1, 16'h0000, 8'h60);
    tx_q = tx_q[0:4];
    tx_q[4][35:32] = 4'b0010;
    send_q();
    exp_drop++;
    check("hdr_eof_nwords", got_q.size(), 0);
    check("hdr_eof_ndone", done_q.size(), 0);
    check("hdr_eof_drop", drop_count_o, exp_drop);

    // Over-length payload.
    clear_obs();
    build_frame(C_MAC, C_IP, C_PORT, 16'd22, 600, 2'b00, 1'b1, 16'h0000, 8'h70);
    send_q();
    exp_drop++;
    check_payload("ovf", 512);
    check("ovf_ndone", done_q.size(), 1);
    if (done_q.size() == 1) check("ovf_err_size", done_q[0], {1'b1, 9'd511});
    check("ovf_drop", drop_count_o, exp_drop);

    // IP header checksum corrupted by one.
    clear_obs();
    build_frame(C_MAC, C_IP, C_PORT, 16'd22, 4, 2'b00, 1'b1, 16'h0001, 8'h80);
    send_q();
`ifdef RX_IP_CHECKSUM_EN
    exp_drop++;
    check_payload("csum", 0);
    check("csum_ndone", done_q.size(), 0);
`else
    check_payload("csum", 4);
    check("csum_ndone", done_q.size(), 1);
    if (done_q.size() == 1) check("csum_err_size", done_q[0], {1'b0, 9'd3});
`endif
    check("csum_drop", drop_count_o, exp_drop);

    // Runt (SOF and EOF together), then a clean frame still gets through.
    clear_obs();
    tx_q.push_back({4'b0011, 32'h0037_ffff});
    build_frame(C_MAC, C_IP, C_PORT, 16'd14, 2, 2'b00, 1'b1, 16'h0000, 8'h90);
    send_q();
    check_payload("runt", 2);
    check("runt_ndone", done_q.size(), 1);
    if (done_q.size() == 1) check("runt_next_err_size", done_q[0], {1'b0, 9'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
